load_store_unit: RTL and testbench

Memory-access stage directly downstream of the ALU. Takes the effective address produced by the ALU's first-cycle `add_result` together with the load/store function code. Runs one valid/ready transaction on the data bus and returns lane-aligned, sign/zero-extended load data or store completion to writeback. One access in flight at a time. Multi-cycle bus stalls are absorbed by a small state machine.

---
 rtl/load_store_unit.sv | 103 ++++++++++
 tb/tb_load_store_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: one-outstanding load/store bus stage; define MISALIGN_CHECK_EN to fault misaligned H/W accesses
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct,
  input  logic [31:0] req_address,
  input  logic [31:0] req_store_data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_address,
  output logic        mem_write,
  output logic [3:0]  mem_strobe,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_misaligned
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0] strobe_q, strobe_d;
  logic [2:0] funct_q, funct_d;
  logic [1:0] off_q, off_d, o;
  logic write_q, write_d, mis_q, mis_d, is_b, is_h, misaligned;
  logic [7:0] lb;
  logic [15:0] lh;
  logic [31:0] load_val;
  always_comb begin
    o = req_address[1:0];
    is_b = req_funct[1:0] == 2'b00;
    is_h = req_funct[1:0] == 2'b01;
`ifdef MISALIGN_CHECK_EN
    misaligned = (is_h & o[0]) | (~is_b & ~is_h & (o != 2'b00));
`else
    misaligned = 1'b0;
`endif
    lb = 8'(mem_rdata >> {off_q, 3'b000});
    lh = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_val = funct_q[1:0] == 2'b00 ? {{24{lb[7] & ~funct_q[2]}}, lb} :
               funct_q[1:0] == 2'b01 ? {{16{lh[15] & ~funct_q[2]}}, lh} : mem_rdata;
    state_d = state_q;
    addr_d = addr_q;
    write_d = write_q;
    strobe_d = strobe_q;
    wdata_d = wdata_q;
    funct_d = funct_q;
    off_d = off_q;
    rdata_d = rdata_q;
    mis_d = mis_q;
    if (state_q == IDLE && req_valid) begin
      addr_d = {req_address[31:2], 2'b00};
      write_d = req_write;
      funct_d = req_funct;
      off_d = o;
      strobe_d = !req_write ? 4'b0000 : is_b ? 4'b0001 << o : is_h ? 4'b0011 << {o[1], 1'b0} : 4'b1111;
      wdata_d = is_b ? {4{req_store_data[7:0]}} : is_h ? {2{req_store_data[15:0]}} : req_store_data;
      mis_d = misaligned;
      rdata_d = misaligned ? req_address : rdata_q;
      state_d = misaligned ? RESP : BUS;
    end
    if (state_q == BUS && mem_ready) begin
      rdata_d = write_q ? 32'h0 : load_val;
      state_d = RESP;
    end
    if (state_q == RESP) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      write_q <= 1'b0;
      strobe_q <= '0;
      wdata_q <= '0;
      funct_q <= '0;
      off_q <= '0;
      rdata_q <= '0;
      mis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      write_q <= write_d;
      strobe_q <= strobe_d;
      wdata_q <= wdata_d;
      funct_q <= funct_d;
      off_q <= off_d;
      rdata_q <= rdata_d;
      mis_q <= mis_d;
    end
  end
  assign req_ready = state_q == IDLE;
  assign mem_valid = state_q == BUS;
  assign resp_valid = state_q == RESP;
  assign mem_address = addr_q;
  assign mem_write = write_q;
  assign mem_strobe = strobe_q;
  assign mem_wdata = wdata_q;
  assign resp_data = rdata_q;
  assign resp_misaligned = mis_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized scoreboard bench with a byte-memory reference model and a stalling bus slave
module tb_load_store_unit;
  logic clk = 0, reset = 1, req_valid = 0, req_write = 0, mem_ready = 0;
  logic [2:0] req_funct = 0;
  logic [31:0] req_address = 0, req_store_data = 0, mem_rdata = 0;
  logic req_ready, mem_valid, mem_write, resp_valid, resp_misaligned;
  logic [3:0] mem_strobe;
  logic [31:0] mem_address, mem_wdata, resp_data;

  load_store_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct(req_funct), .req_address(req_address),
    .req_store_data(req_store_data), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_address(mem_address), .mem_write(mem_write), .mem_strobe(mem_strobe),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_misaligned(resp_misaligned)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] a; logic w; logic [3:0] s; logic [31:0] d;} bus_t;
  typedef struct packed {logic [31:0] d; logic m;} resp_t;
  bus_t bus_q[$];
  resp_t resp_q[$];
  byte unsigned mm[int unsigned];
  logic [31:0] sm[int unsigned];
  int tests = 0, fails = 0;
  int force_stall = -1;

  function automatic logic [31:0] iw(input logic [31:0] w);
    return w == 32'h1000 ? 32'h80FF_0000 : w == 32'h1004 ? 32'hDEAD_BEEF : (w * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [7:0] mb(input logic [31:0] a);
    if (mm.exists(a)) return mm[a];
    return 8'(iw(a & ~32'd3) >> (8 * (a & 32'd3)));
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", n, act, exp);
    end
  endtask

  // bus slave: word memory, per-access stall count, random mem_ready outside BUS
  bit busy = 0;
  int cnt = 0;
  logic [31:0] sw;
  always @(posedge clk) begin
    #1;
    if (mem_valid) begin
      if (!busy) begin
        busy = 1;
        cnt = force_stall >= 0 ? force_stall : int'($urandom_range(0, 4));
      end
      mem_ready = cnt == 0;
      if (cnt > 0) cnt--;
    end else begin
      busy = 0;
      mem_ready = 1'($urandom_range(0, 1));
    end
    mem_rdata = sm.exists(mem_address) ? sm[mem_address] : iw(mem_address);
  end
  always @(negedge clk) begin
    if (!reset && mem_valid && mem_ready && mem_write) begin
      sw = sm.exists(mem_address) ? sm[mem_address] : iw(mem_address);
      for (int i = 0; i < 4; i++) if (mem_strobe[i]) sw[8*i+:8] = mem_wdata[8*i+:8];
      sm[mem_address] = sw;
    end
  end

  // monitor: pops expectations whenever the DUT presents a bus request or a response
  int cyc = 0, acc_cyc = 0, hs_cyc = 0;
  bit seen_bus = 0, prev_stall = 0;
  logic [31:0] pa, pd;
  logic pw;
  logic [3:0] ps;
  bus_t eb;
  resp_t er;
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      seen_bus = 0;
      prev_stall = 0;
    end else begin
      if (mem_valid) begin
        chk("bus_req_ready_low", req_ready, 0);
        if (!seen_bus) begin
          seen_bus = 1;
          chk("bus_latency", cyc, acc_cyc + 1);
          if (bus_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_bus: mem_valid at addr %h, required no access", mem_address);
          end else begin
            eb = bus_q.pop_front();
            chk("mem_address", mem_address, eb.a);
            chk("mem_write", mem_write, eb.w);
            chk("mem_strobe", mem_strobe, eb.s);
            if (eb.w) chk("mem_wdata", mem_wdata, eb.d);
          end
        end
        if (prev_stall) begin
          chk("stall_addr", mem_address, pa);
          chk("stall_write", mem_write, pw);
          chk("stall_strobe", mem_strobe, ps);
          chk("stall_wdata", mem_wdata, pd);
        end
        prev_stall = !mem_ready;
        pa = mem_address; pw = mem_write; ps = mem_strobe; pd = mem_wdata;
        if (mem_ready) hs_cyc = cyc;
      end else prev_stall = 0;
      if (resp_valid) begin
        chk("resp_latency", cyc, seen_bus ? hs_cyc + 1 : acc_cyc + 1);
        chk("resp_req_ready_low", req_ready, 0);
        if (resp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_resp: resp_valid with data %h, required none", resp_data);
        end else begin
          er = resp_q.pop_front();
          chk("resp_data", resp_data, er.d);
          chk("resp_misaligned", resp_misaligned, er.m);
        end
        seen_bus = 0;
      end
      if (req_valid && req_ready) begin
        acc_cyc = cyc;
        seen_bus = 0;
      end
    end
  end

  task automatic issue(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d, input int stall);
    int t, sz;
    logic [31:0] ea, v;
    bit mis;
    bus_t b;
    resp_t r;
    force_stall = stall;
    req_valid = 1; req_write = w; req_funct = f; req_address = a; req_store_data = d;
    t = 0;
    do begin @(negedge clk); t++; end while (!req_ready && t < 50);
    if (!req_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: req_ready %b, required 1", req_ready);
    end else begin
      sz = f[1:0] == 2'b00 ? 1 : f[1:0] == 2'b01 ? 2 : 4;
      ea = a & ~32'(sz - 1);
      mis = 0;
`ifdef MISALIGN_CHECK_EN
      mis = ea != a;
`endif
      if (mis) r = '{a, 1'b1};
      else begin
        v = 0;
        for (int i = 0; i < sz; i++) v |= 32'(mb(ea + i)) << (8 * i);
        if (!f[2] && sz < 4 && v[8*sz-1]) v |= ~32'h0 << (8 * sz);
        if (w) for (int i = 0; i < sz; i++) mm[ea + i] = 8'(d >> (8 * i));
        b.a = a & ~32'd3;
        b.w = w;
        b.s = w ? 4'(((1 << sz) - 1) << (ea & 32'd3)) : 4'b0000;
        b.d = sz == 1 ? d[7:0] * 32'h0101_0101 : sz == 2 ? d[15:0] * 32'h0001_0001 : d;
        bus_q.push_back(b);
        r = '{w ? 32'h0 : v, 1'b0};
      end
      resp_q.push_back(r);
    end
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_mis", resp_misaligned, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_strobe", mem_strobe, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_resp_data", resp_data, 0);
    @(posedge clk); #1;
    issue(0, 3'b010, 32'h0000_1004, 32'h0, 0);
    issue(0, 3'b000, 32'h0000_1003, 32'h0, 0);
    issue(0, 3'b100, 32'h0000_1003, 32'h0, 1);
    issue(1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 0);
    issue(0, 3'b001, 32'h0000_2002, 32'h0, 2);
    issue(0, 3'b010, 32'h0000_1004, 32'h0, 5);
    issue(0, 3'b010, 32'h0000_3001, 32'h0, 0);
    issue(1, 3'b010, 32'h0000_3003, 32'hCAFE_F00D, 0);
    issue(0, 3'b101, 32'h0000_3001, 32'h0, 0);
    for (int n = 0; n < 300; n++) begin
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            $urandom_range(0, 3) == 0 ? $urandom : 32'h4000 + $urandom_range(0, 63), $urandom, -1);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    force_stall = 1000;
    req_valid = 1; req_write = 0; req_funct = 3'b010; req_address = 32'h4000;
    t = 0;
    do begin @(negedge clk); t++; end while (!req_ready && t < 50);
    bus_q.push_back('{32'h4000, 1'b0, 4'b0000, 32'h0});
    @(posedge clk); #1 req_valid = 0;
    t = 0;
    do begin @(negedge clk); t++; end while (!mem_valid && t < 10);
    chk("rstbus_mem_valid_before", mem_valid, 1);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("rstbus_mem_valid", mem_valid, 0);
    chk("rstbus_req_ready", req_ready, 1);
    chk("rstbus_resp_valid", resp_valid, 0);
    chk("rstbus_mem_address", mem_address, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rstbus_no_resp", resp_valid, 0);
    end
    force_stall = -1;
    @(posedge clk); #1;
    issue(0, 3'b000, 32'h0000_1003, 32'h0, 0);
    repeat (6) @(negedge clk);
    chk("resp_queue_drained", resp_q.size(), 0);
    chk("bus_queue_drained", bus_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
